// File: rtl/bm_lut_xlate_if.sv
// Request, table-write and result signals of the LUT translator, grouped
// so a requester and the translator share one bundle.
interface bm_lut_xlate_if #(
  parameter int BITS = 4
);
  logic            in_valid;
  logic [BITS-1:0] a_in;
  logic [1:0]      mode;
  logic            wr_en;
  logic [BITS-1:0] wr_addr;
  logic [BITS-1:0] wr_data;
  logic            busy;
  logic            out_valid;
  logic [BITS-1:0] out0;

  modport master (
    output in_valid, a_in, mode, wr_en, wr_addr, wr_data,
    input  busy, out_valid, out0
  );

  modport slave (
    input  in_valid, a_in, mode, wr_en, wr_addr, wr_data,
    output busy, out_valid, out0
  );
endinterface

// File: rtl/bm_lut_xlate.sv
// Two-stage operand translator backed by a 2^BITS-entry table that fills
// itself with ~index after reset, then accepts user writes and lookups.
module bm_lut_xlate #(
  parameter int BITS = 4
) (
  input logic          clock,
  input logic          reset,
  bm_lut_xlate_if.slave bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nx;
  logic [BITS-1:0] cnt, cnt_nx;
  logic            tbl_we;
  logic [BITS-1:0] tbl_wa, tbl_wd;
  logic [BITS-1:0] tbl [2**BITS];

  logic            s1_valid;
  logic [BITS-1:0] s1_a;
  logic [1:0]      s1_mode;
  logic [BITS-1:0] rd, result;
  logic            accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The init walker owns the table write port until the last entry is
  // written; cnt then parks at all-ones instead of wrapping.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tbl_we   = 1'b0;
    tbl_wa   = bus.wr_addr;
    tbl_wd   = bus.wr_data;
    case (state)
      INIT: begin
        tbl_we = 1'b1;
        tbl_wa = cnt;
        tbl_wd = ~cnt;
        if (cnt == '1) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        tbl_we = bus.wr_en;
      end
      default: state_nx = INIT;
    endcase
  end

  assign bus.busy = (state == INIT);
  assign accept   = bus.in_valid && (state == RUN);

  always_ff @(posedge clock) begin
    if (tbl_we) begin
      tbl[tbl_wa] <= tbl_wd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_mode  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a    <= bus.a_in;
        s1_mode <= bus.mode;
      end
    end
  end

  // Reading here while the write lands on the same edge yields the old word.
  assign rd = tbl[s1_a];

  always_comb begin
    result = s1_a;
    case (s1_mode)
      2'b00:   result = ~s1_a;
      2'b01:   result = rd;
      2'b10:   result = s1_a;
      default: result = ~rd;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out0      <= '0;
    end else begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out0 <= result;
      end
    end
  end

endmodule

// File: tb/tb_bm_lut_xlate.sv
// Directed scoreboard bench for bm_lut_xlate (BITS=4 main instance, BITS=6 init/lookup).
module tb_bm_lut_xlate;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic reset6 = 1'b1;

  always #5 clock = ~clock;

  bm_lut_xlate_if #(.BITS(4)) ifc ();
  bm_lut_xlate_if #(.BITS(6)) ifc6 ();

  bm_lut_xlate #(.BITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  bm_lut_xlate #(.BITS(6)) dut6 (
    .clock (clock),
    .reset (reset6),
    .bus   (ifc6)
  );

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && ifc.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out0=%0h expected no output", ifc.out0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out0", 32'(ifc.out0), 32'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic req(input logic [3:0] a, input logic [1:0] m, input logic [3:0] e);
    ifc.in_valid = 1'b1;
    ifc.a_in     = a;
    ifc.mode     = m;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic tbl_write(input logic [3:0] a, input logic [3:0] d);
    ifc.wr_en   = 1'b1;
    ifc.wr_addr = a;
    ifc.wr_data = d;
    @(posedge clock);
    #1;
    ifc.wr_en = 1'b0;
  endtask

  // Counts negedges with busy high; results must stay silent and zero meanwhile.
  task automatic wait_init(input string name, input int n);
    int c = 0;
    bit bad = 1'b0;
    @(negedge clock);
    while (ifc.busy && c < 200) begin
      c++;
      if (ifc.out_valid || ifc.out0 != 4'h0) bad = 1'b1;
      @(negedge clock);
    end
    check({name, "_busy_cycles"}, c, n);
    check({name, "_quiet_outputs"}, 32'(bad), 32'd0);
  endtask

  logic [3:0] va[11] = '{4'h0, 4'h9, 4'h9, 4'h9, 4'h9, 4'hC, 4'h7, 4'h5, 4'h5, 4'hE, 4'h1};
  logic [1:0] vm[11] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0};
  logic [3:0] ve[11] = '{4'hF, 4'h6, 4'h6, 4'h9, 4'h9, 4'hC, 4'h7, 4'h5, 4'hA, 4'h1, 4'hE};

  initial begin
    int c6;
    ifc.in_valid = 1'b0; ifc.a_in = '0; ifc.mode = '0;
    ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
    ifc6.in_valid = 1'b0; ifc6.a_in = '0; ifc6.mode = '0;
    ifc6.wr_en = 1'b0; ifc6.wr_addr = '0; ifc6.wr_data = '0;

    repeat (3) @(posedge clock);
    #1;
    check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset_out0", 32'(ifc.out0), 32'd0);
    check("reset_busy", 32'(ifc.busy), 32'd1);

    // Request held high throughout initialisation.
    ifc.in_valid = 1'b1; ifc.a_in = 4'h0; ifc.mode = 2'b01;
    reset = 1'b0;
    wait_init("init", 16);
    exp_q.push_back(4'hF);
    @(posedge clock);
    #1;
    for (int i = 0; i < 16; i++) req(4'(i), 2'b01, 4'(15 - i));
    idle(3);

    tbl_write(4'h5, 4'hA);
    req(4'h5, 2'b01, 4'hA);
    req(4'h5, 2'b11, 4'h5);
    req(4'h5, 2'b00, 4'hA);
    req(4'h5, 2'b10, 4'h5);
    idle(3);

    for (int i = 0; i < 11; i++) req(va[i], vm[i], ve[i]);
    idle(3);

    // Write lands on the first request's read edge and the second's capture edge.
    req(4'h3, 2'b01, 4'hC);
    ifc.in_valid = 1'b1; ifc.a_in = 4'h3; ifc.mode = 2'b01;
    exp_q.push_back(4'h0);
    ifc.wr_en = 1'b1; ifc.wr_addr = 4'h3; ifc.wr_data = 4'h0;
    @(posedge clock);
    #1;
    ifc.in_valid = 1'b0; ifc.wr_en = 1'b0;
    idle(1);
    req(4'h3, 2'b01, 4'h0);
    req(4'h3, 2'b11, 4'hF);
    idle(3);
    check("drained_before_reset", exp_q.size(), 0);

    tbl_write(4'h5, 4'h1);
    req(4'h5, 2'b01, 4'h1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("midreset_out0", 32'(ifc.out0), 32'd0);
    check("midreset_busy", 32'(ifc.busy), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    wait_init("reinit", 16);
    @(posedge clock);
    #1;
    req(4'h5, 2'b01, 4'hA);
    req(4'h3, 2'b01, 4'hC);
    idle(4);
    check("scoreboard_drained", exp_q.size(), 0);

    // Wider build: 64-cycle init and one lookup.
    reset6 = 1'b0;
    c6 = 0;
    @(negedge clock);
    while (ifc6.busy && c6 < 400) begin
      c6++;
      @(negedge clock);
    end
    check("bits6_busy_cycles", c6, 64);
    ifc6.in_valid = 1'b1; ifc6.a_in = 6'h01; ifc6.mode = 2'b01;
    @(posedge clock);
    #1;
    ifc6.in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("bits6_out_valid", 32'(ifc6.out_valid), 32'd1);
    check("bits6_out0", 32'(ifc6.out0), 32'h3E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bm_lut_xlate.md
BM_LUT_XLATE -- requirements
Module: bm_lut_xlate

Interface
REQ-001 Parameter BITS, default 4, SHALL set operand/table-word width; table depth SHALL be 2^BITS.
REQ-002 clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL qualify a_in and mode as a lookup request.
REQ-005 a_in  input  BITS  SHALL be the lookup operand/table address.
REQ-006 mode  input  2  SHALL select the translation: 00 invert, 01 table, 10 identity, 11 table-then-invert.
REQ-007 wr_en  input  1  SHALL request a table write.
REQ-008 wr_addr  input  BITS  SHALL be the table write address.
REQ-009 wr_data  input  BITS  SHALL be the table write data.
REQ-010 busy  output  1  SHALL be high while the table self-initialises.
REQ-011 out_valid  output  1  SHALL qualify out0.
REQ-012 out0  output  BITS  SHALL be the registered translation result.

Function
REQ-013 FSM SHALL have two states: INIT and RUN; reset SHALL force INIT with init counter = 0.
REQ-014 In INIT, each cycle SHALL write table[cnt] = ~cnt (bitwise inverse, BITS wide) and increment cnt.
REQ-015 INIT SHALL last exactly 2^BITS cycles; on writing entry 2^BITS-1 it SHALL move to RUN; counter SHALL not wrap into a second pass.
REQ-016 busy SHALL equal 1 in INIT and 0 in RUN.
REQ-017 In INIT, in_valid and wr_en SHALL be ignored: no pipeline entry, no user write.
REQ-018 Pipeline SHALL be 2 stages: edge E1 captures in_valid, a_in, mode into stage 1; edge E2 registers out0/out_valid from stage 1.
REQ-019 Latency SHALL be 2 cycles; throughput one request per cycle, no back-pressure.
REQ-020 Stage-2 result: 00 -> ~a; 01 -> table[a]; 10 -> a; 11 -> ~table[a]; a = stage-1 operand, all arithmetic BITS wide, no overflow possible.
REQ-021 In RUN, wr_en SHALL write table[wr_addr] = wr_data at the rising edge.
REQ-022 Table read at E2 SHALL return contents before any write at the same edge E2 (read-before-write); a write at E1 or earlier SHALL be visible.
REQ-023 out_valid SHALL be the stage-1 valid delayed one edge; when out_valid = 0, out0 SHALL hold its previous value.
REQ-024 Stage-1 capture SHALL occur only when in_valid = 1 and state = RUN; otherwise stage-1 valid SHALL be 0.
REQ-025 The last INIT cycle SHALL not accept a request; first accepted request SHALL be in the first cycle with busy = 0.
REQ-026 Mode SHALL be sampled per request; changing mode between back-to-back requests SHALL affect only the new request.

Reset
REQ-027 On reset assertion, immediately: out0 = 0, out_valid = 0, busy = 1, stage-1 valid = 0, state = INIT, cnt = 0.
REQ-028 Reset mid-operation SHALL discard in-flight requests and SHALL restart full table initialisation, overwriting all user-written entries.
REQ-029 Table contents need no reset value; REQ-014 defines them before RUN.

Verification
REQ-030 Reset, BITS=4, hold in_valid=1 -> busy high exactly 16 cycles, no out_valid during INIT, then busy=0.
REQ-031 RUN, mode=01, a_in sweeps 0..15 back-to-back -> out0 = 15..0 two cycles after each request, out_valid continuous 16 cycles.
REQ-032 Write table[5]=4'hA, then next cycle mode=01 a_in=5 -> out0=4'hA; mode=11 a_in=5 -> out0=4'h5; mode=00 a_in=5 -> 4'hA; mode=10 a_in=5 -> 4'h5.
REQ-033 Request mode=01 a_in=3 at cycle T, wr_en wr_addr=3 wr_data=0 at cycle T+1 -> out0=4'hC (old value); repeat request -> out0=0.
REQ-034 Assert reset one cycle after a request with in-flight data -> out_valid stays 0, out0=0, busy=1 for 16 cycles, table[5] back to 4'hA (=~5).
REQ-035 BITS=6 build: INIT lasts 64 cycles; mode=01 a_in=6'h01 -> 6'h3E.
